// File: rtl/test_pkg.sv
// Shared FSM state encoding and default parameter values for the test sequencer.
package test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam int unsigned DEF_N_CH       = 2;
  localparam int unsigned DEF_SIG_W      = 32;
  localparam int unsigned DEF_CNT_W      = 16;
  localparam int unsigned DEF_RST_CYCLES = 4;
  localparam int unsigned DEF_TIMEOUT    = 256;

endpackage

// File: rtl/test_sequencer_halt_capture.sv
// One channel's sticky halt flag and the result signature seen on the halt cycle.
module halt_capture #(
  parameter int unsigned SIG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             halt,
  input  logic [SIG_W-1:0] result,
  output logic             halted,
  output logic [SIG_W-1:0] sig
);

  // Latch flag and signature on the first enabled halt; ignore later changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted <= 1'b0;
      sig    <= '0;
    end else if (clr) begin
      halted <= 1'b0;
      sig    <= '0;
    end else if (en && halt && !halted) begin
      halted <= 1'b1;
      sig    <= result;
    end
  end

endmodule

// File: rtl/test_sequencer.sv
// Run sequencer: resets the CPUs under test, counts run cycles, waits for all
// channels to halt (or the cycle limit) and checks their result signatures.
module test_sequencer
  import test_pkg::*;
#(
  parameter int unsigned N_CH       = DEF_N_CH,
  parameter int unsigned SIG_W      = DEF_SIG_W,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned RST_CYCLES = DEF_RST_CYCLES,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N_CH-1:0]       halt_i,
  input  logic [N_CH*SIG_W-1:0] result_i,
  input  logic [SIG_W-1:0]      expect_i,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [CNT_W-1:0]      cycles,
  output logic [N_CH-1:0]       fail_mask
);

  localparam int unsigned RW = $clog2(RST_CYCLES + 1);
  localparam logic [RW-1:0]    RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(TIMEOUT - 1);

  state_t          state, state_n;
  logic [RW-1:0]   rst_cnt;
  logic            clr, run_en, cnt_inc, go_timeout, go_check;
  logic [N_CH-1:0] halted, halted_now, mismatch;
  logic [SIG_W-1:0] sig [N_CH];

  genvar k;
  generate
    for (k = 0; k < N_CH; k++) begin : g_ch
      halt_capture #(.SIG_W(SIG_W)) u_cap (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .en     (run_en),
        .halt   (halt_i[k]),
        .result (result_i[k*SIG_W +: SIG_W]),
        .halted (halted[k]),
        .sig    (sig[k])
      );
      assign mismatch[k] = (sig[k] != expect_i);
    end
  endgenerate

  // Flags as they will stand after this edge, so a halt on this cycle counts.
  assign halted_now = halted | halt_i;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next-state decode and per-cycle datapath strobes.
  always_comb begin
    state_n    = state;
    clr        = 1'b0;
    run_en     = 1'b0;
    cnt_inc    = 1'b0;
    go_timeout = 1'b0;
    go_check   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_n = ST_RESET;
          clr     = 1'b1;
        end
      end
      ST_RESET: begin
        if (rst_cnt == RST_LAST) state_n = ST_RUN;
      end
      ST_RUN: begin
        run_en = 1'b1;
        // A last halt on the final allowed cycle takes priority over timeout.
        if (&halted_now) begin
          state_n = ST_CHECK;
        end else if (cycles == CYC_LAST) begin
          state_n    = ST_DONE;
          go_timeout = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_CHECK: begin
        state_n  = ST_DONE;
        go_check = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Registered outputs, reset-phase counter, run counter and verdict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rst   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      cycles    <= '0;
      fail_mask <= '0;
      rst_cnt   <= '0;
    end else begin
      cpu_rst <= !(state_n == ST_RUN || state_n == ST_CHECK);
      busy    <= (state_n == ST_RESET || state_n == ST_RUN || state_n == ST_CHECK);
      done    <= (state_n == ST_DONE);
      if (clr) begin
        cycles    <= '0;
        pass      <= 1'b0;
        timeout   <= 1'b0;
        fail_mask <= '0;
        rst_cnt   <= '0;
      end else if (state == ST_RESET) begin
        rst_cnt <= rst_cnt + RW'(1);
      end
      if (cnt_inc) cycles <= cycles + CNT_W'(1);
      if (go_timeout) begin
        timeout   <= 1'b1;
        pass      <= 1'b0;
        fail_mask <= ~halted_now;
      end
      if (go_check) begin
        fail_mask <= mismatch;
        pass      <= ~|mismatch;
        timeout   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_test_sequencer.sv
// Directed bench for test_sequencer with default parameters.
module tb_test_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  halt_i;
  logic [63:0] result_i;
  logic [31:0] expect_i;
  logic        cpu_rst, busy, done, pass, timeout;
  logic [15:0] cycles;
  logic [1:0]  fail_mask;

  int tests = 0;
  int fails = 0;

  test_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .halt_i    (halt_i),
    .result_i  (result_i),
    .expect_i  (expect_i),
    .cpu_rst   (cpu_rst),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .timeout   (timeout),
    .cycles    (cycles),
    .fail_mask (fail_mask)
  );

  always #5 clk = ~clk;

  // Pulse start for one edge; returns at the negedge after the accepting edge.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Advance negedges until the run is at RUN cycle c (bounded).
  task automatic wait_cycle(input int c, input string tag);
    int n = 0;
    while (!(busy && !cpu_rst && cycles == 16'(c)) && n < 600) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 600) begin
      fails++;
      $display("FAIL %s: never reached cycle %0d (cycles=%0d busy=%0b)", tag, c, cycles, busy);
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 600) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 600) begin
      fails++;
      $display("FAIL %s: done never rose (cycles=%0d)", tag, cycles);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; halt_i = '0; result_i = '0; expect_i = 32'hAA;
    repeat (2) @(negedge clk);
    tests++;
    if ({cpu_rst, busy, done, pass, timeout, cycles, fail_mask} !== {1'b1, 4'b0, 16'd0, 2'b00}) begin
      fails++;
      $display("FAIL reset_state: got cpu_rst=%0b busy=%0b done=%0b pass=%0b to=%0b cyc=%0d mask=%b",
               cpu_rst, busy, done, pass, timeout, cycles, fail_mask);
    end
    rst = 1'b0;
    pulse_start();
    // Four cycles of RESET: after the accepting edge and three more.
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (cpu_rst !== 1'b1 || busy !== 1'b1) begin
        fails++;
        $display("FAIL reset_hold[%0d]: cpu_rst=%0b busy=%0b, want 1 1", i, cpu_rst, busy);
      end
      if (i < 3) @(negedge clk);
    end
    @(negedge clk);
    tests++;
    if (cpu_rst !== 1'b0 || busy !== 1'b1 || cycles !== 16'd0) begin
      fails++;
      $display("FAIL reset_release: cpu_rst=%0b busy=%0b cyc=%0d, want 0 1 0", cpu_rst, busy, cycles);
    end
    @(negedge clk);
    tests++;
    if (cycles !== 16'd1) begin
      fails++;
      $display("FAIL run_count: cycles=%0d, want 1", cycles);
    end
    // Leave this run to time out quietly is too long; abort it instead.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_pass();
    halt_i = '0; result_i = '0; expect_i = 32'h0000_00AA;
    pulse_start();
    wait_cycle(10, "pass_wait");
    halt_i = 2'b11;
    result_i = {32'h0000_00AA, 32'h0000_00AA};
    @(negedge clk);
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL pass_check_state: busy=%0b done=%0b, want 1 0", busy, done);
    end
    wait_done("pass_done");
    tests++;
    if ({pass, timeout, fail_mask, cycles, cpu_rst, busy} !== {1'b1, 1'b0, 2'b00, 16'd10, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL pass_verdict: pass=%0b to=%0b mask=%b cyc=%0d cpu_rst=%0b busy=%0b, want 1 0 00 10 1 0",
               pass, timeout, fail_mask, cycles, cpu_rst, busy);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (done !== 1'b1 || pass !== 1'b1 || cycles !== 16'd10) begin
      fails++;
      $display("FAIL pass_hold: done=%0b pass=%0b cyc=%0d, want 1 1 10", done, pass, cycles);
    end
  endtask

  task automatic test_stagger();
    halt_i = '0; result_i = '0; expect_i = 32'h0000_00AA;
    pulse_start();
    wait_cycle(5, "stag_wait5");
    halt_i = 2'b01;
    result_i[31:0] = 32'h0000_00AA;
    @(negedge clk);
    result_i[31:0] = 32'h0000_0055;
    wait_cycle(8, "stag_wait8");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (cycles !== 16'd9 || busy !== 1'b1) begin
      fails++;
      $display("FAIL stag_start_ignored: cyc=%0d busy=%0b, want 9 1", cycles, busy);
    end
    wait_cycle(20, "stag_wait20");
    halt_i = 2'b11;
    result_i[63:32] = 32'h0000_00BB;
    wait_done("stag_done");
    tests++;
    if ({pass, timeout, fail_mask, cycles} !== {1'b0, 1'b0, 2'b10, 16'd20}) begin
      fails++;
      $display("FAIL stag_verdict: pass=%0b to=%0b mask=%b cyc=%0d, want 0 0 10 20",
               pass, timeout, fail_mask, cycles);
    end
  endtask

  task automatic test_timeout();
    halt_i = '0; result_i = '0; expect_i = 32'h0000_00AA;
    pulse_start();
    wait_cycle(3, "to_wait3");
    halt_i = 2'b01;
    result_i[31:0] = 32'h0000_00AA;
    wait_cycle(254, "to_wait254");
    tests++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL to_early: done=%0b busy=%0b at 254, want 0 1", done, busy);
    end
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({done, timeout, pass, fail_mask, cycles, cpu_rst, busy} !==
        {1'b1, 1'b1, 1'b0, 2'b10, 16'd255, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL to_verdict: done=%0b to=%0b pass=%0b mask=%b cyc=%0d cpu_rst=%0b busy=%0b, want 1 1 0 10 255 1 0",
               done, timeout, pass, fail_mask, cycles, cpu_rst, busy);
    end
  endtask

  task automatic test_simultaneous();
    halt_i = '0; result_i = '0; expect_i = 32'h0000_00AA;
    // Launched from DONE after a timeout: status must come back cleared.
    pulse_start();
    tests++;
    if ({done, pass, timeout, fail_mask, cycles, busy} !== {1'b0, 1'b0, 1'b0, 2'b00, 16'd0, 1'b1}) begin
      fails++;
      $display("FAIL restart_clear: done=%0b pass=%0b to=%0b mask=%b cyc=%0d busy=%0b, want 0 0 0 00 0 1",
               done, pass, timeout, fail_mask, cycles, busy);
    end
    wait_cycle(100, "sim_wait100");
    halt_i = 2'b01;
    result_i[31:0] = 32'h0000_00AA;
    wait_cycle(255, "sim_wait255");
    halt_i = 2'b11;
    result_i[63:32] = 32'h0000_00AA;
    wait_done("sim_done");
    tests++;
    if ({pass, timeout, fail_mask, cycles} !== {1'b1, 1'b0, 2'b00, 16'd255}) begin
      fails++;
      $display("FAIL sim_verdict: pass=%0b to=%0b mask=%b cyc=%0d, want 1 0 00 255",
               pass, timeout, fail_mask, cycles);
    end
  endtask

  task automatic test_abort();
    halt_i = '0; result_i = '0; expect_i = 32'h0000_00AA;
    pulse_start();
    wait_cycle(7, "abort_wait");
    halt_i = 2'b01;
    result_i[31:0] = 32'h0000_00AA;
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({cpu_rst, busy, done, pass, timeout, cycles, fail_mask} !== {1'b1, 4'b0, 16'd0, 2'b00}) begin
      fails++;
      $display("FAIL abort_async: cpu_rst=%0b busy=%0b done=%0b pass=%0b to=%0b cyc=%0d mask=%b",
               cpu_rst, busy, done, pass, timeout, cycles, fail_mask);
    end
    @(negedge clk);
    rst = 1'b0;
    halt_i = '0;
    repeat (5) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || cpu_rst !== 1'b1) begin
      fails++;
      $display("FAIL abort_idle: busy=%0b done=%0b cpu_rst=%0b, want 0 0 1", busy, done, cpu_rst);
    end
    // Fresh run from IDLE: ch0's capture from the aborted run must be gone.
    result_i = {32'h0000_00AA, 32'h0000_0011};
    pulse_start();
    wait_cycle(2, "abort_run_wait");
    halt_i = 2'b11;
    wait_done("abort_run_done");
    tests++;
    if ({pass, timeout, fail_mask, cycles} !== {1'b0, 1'b0, 2'b01, 16'd2}) begin
      fails++;
      $display("FAIL abort_run_verdict: pass=%0b to=%0b mask=%b cyc=%0d, want 0 0 01 2",
               pass, timeout, fail_mask, cycles);
    end
    // Halts already asserted on the first RUN cycle count immediately.
    result_i = {32'h0000_00AA, 32'h0000_00AA};
    halt_i = 2'b00;
    pulse_start();
    halt_i = 2'b11;
    wait_done("first_cycle_done");
    tests++;
    if ({pass, timeout, fail_mask, cycles} !== {1'b1, 1'b0, 2'b00, 16'd0}) begin
      fails++;
      $display("FAIL first_cycle_verdict: pass=%0b to=%0b mask=%b cyc=%0d, want 1 0 00 0",
               pass, timeout, fail_mask, cycles);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_stagger();
    test_timeout();
    test_simultaneous();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
